// File: rtl/sap1_pkg.sv
// ---------------------------------------------------------------------------
// sap1_pkg
// Shared constants for the SAP-1 control path:
//   - opcode encodings (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
//   - T-state bit indices into the one-hot ring (T1_IDX..T6_IDX)
//   - RING_LEN, the number of T-states
//   - control-word bit positions (CW_*), so a bench or debug port can pack
//     the individual strobes into one vector in a common order
// ---------------------------------------------------------------------------
package sap1_pkg;

    localparam int OPCODE_W = 4;
    localparam int RING_LEN = 6;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

    // Ring value for T1; also the reset / reload value.
    localparam logic [RING_LEN-1:0] T1_ONEHOT = 6'b000001;

    // Control-word packing, MSB first: cp ep lm ce li ei la ea su eu lb lo
    localparam int CW_WIDTH = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

endpackage

// File: rtl/ring_counter.sv
// ---------------------------------------------------------------------------
// ring_counter
// One-hot T-state ring for the SAP-1 controller.
//   i_clk      : clock, state changes on posedge
//   i_clr      : asynchronous active-high clear, forces the ring to T1
//   i_hold     : freeze the ring at its current state (highest priority)
//   i_load_t1  : jump back to T1 at the next edge instead of rotating
//   o_t        : one-hot ring state, bit0 = T1
// ---------------------------------------------------------------------------
module ring_counter
    import sap1_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_clr,
    input  logic                i_hold,
    input  logic                i_load_t1,
    output logic [RING_LEN-1:0] o_t
);

    logic [RING_LEN-1:0] ring_q;
    logic [RING_LEN-1:0] ring_d;
    logic [RING_LEN-1:0] ring_rot;

    // Rotate left by one: bit gi takes the previous state's bit, T6 wraps to T1.
    genvar gi;
    generate
        for (gi = 0; gi < RING_LEN; gi++) begin : g_rot
            assign ring_rot[gi] = ring_q[(gi + RING_LEN - 1) % RING_LEN];
        end
    endgenerate

    always_comb begin
        ring_d = ring_q;
        if (i_hold) begin
            ring_d = ring_q;
        end else if (i_load_t1) begin
            ring_d = T1_ONEHOT;
        end else begin
            ring_d = ring_rot;
        end
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            ring_q <= T1_ONEHOT;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign o_t = ring_q;

endmodule

// File: rtl/controller_sequencer.sv
// ---------------------------------------------------------------------------
// controller_sequencer
// SAP-1 control unit: one-hot T1..T6 ring plus combinational opcode decode
// producing every bus-control strobe, and a sticky halt flag.
//
// Ports:
//   i_clk     : clock, all state changes on posedge
//   i_clr     : asynchronous active-high reset (ring -> T1, halt -> 0,
//               all strobes held low while asserted)
//   i_opcode  : IR upper nibble, meaningful in T4..T6
//   o_t       : one-hot ring state, bit0 = T1
//   o_cp/o_ep : PC increment / PC drives bus
//   o_lm      : MAR load
//   o_ce      : RAM drives bus
//   o_li/o_ei : IR load / IR operand drives bus
//   o_la/o_ea : A load / A drives bus
//   o_su/o_eu : ALU subtract / ALU drives bus
//   o_lb      : B load
//   o_lo      : output-register load
//   o_hlt     : sticky halt flag, cleared only by i_clr
//
// Build option: define SHORT_CYCLE_EN to end OUT after T4 and NOP after T3
// instead of always running all six T-states. Strobes per state are the same
// in both builds.
// ---------------------------------------------------------------------------
module controller_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int RING_LEN     = 6
) (
    input  logic                    i_clk,
    input  logic                    i_clr,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output logic [RING_LEN-1:0]     o_t,
    output logic                    o_cp,
    output logic                    o_ep,
    output logic                    o_lm,
    output logic                    o_ce,
    output logic                    o_li,
    output logic                    o_ei,
    output logic                    o_la,
    output logic                    o_ea,
    output logic                    o_su,
    output logic                    o_eu,
    output logic                    o_lb,
    output logic                    o_lo,
    output logic                    o_hlt
);

    import sap1_pkg::*;

    // The ring length and opcode width are architectural, not tunable.
    generate
        if (RING_LEN != sap1_pkg::RING_LEN) begin : g_bad_ring_len
            $error("controller_sequencer: RING_LEN must be 6");
        end
        if (OPCODE_WIDTH != OPCODE_W) begin : g_bad_opcode_width
            $error("controller_sequencer: OPCODE_WIDTH must be 4");
        end
    endgenerate

    logic [RING_LEN-1:0] t_state;
    logic                halt_q;
    logic                halt_d;
    logic                halt_set;
    logic                load_t1;
    logic [CW_WIDTH-1:0] cw;

    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;
    logic is_nop;
    logic is_mem;

    assign is_lda = (i_opcode == OP_LDA);
    assign is_add = (i_opcode == OP_ADD);
    assign is_sub = (i_opcode == OP_SUB);
    assign is_out = (i_opcode == OP_OUT);
    assign is_hlt = (i_opcode == OP_HLT);
    assign is_nop = ~(is_lda | is_add | is_sub | is_out | is_hlt);
    assign is_mem = is_lda | is_add | is_sub;

    // Halt is taken at the edge that ends T4. The ring must not move on that
    // same edge, so the hold input sees the set condition as well as the flag.
    assign halt_set = ~halt_q & t_state[T4_IDX] & is_hlt;

    always_comb begin
        halt_d = halt_q | halt_set;
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

`ifdef SHORT_CYCLE_EN
    // Return to T1 straight after the last state that has anything to do.
    assign load_t1 = (t_state[T4_IDX] & is_out) | (t_state[T3_IDX] & is_nop);
`else
    assign load_t1 = 1'b0;
`endif

    ring_counter u_ring (
        .i_clk     (i_clk),
        .i_clr     (i_clr),
        .i_hold    (halt_q | halt_set),
        .i_load_t1 (load_t1),
        .o_t       (t_state)
    );

    // Strobe decode. Gating with i_clr keeps every strobe low while reset is
    // held, even though the ring already shows T1 during that time.
    always_comb begin
        cw = '0;
        if (!halt_q && !i_clr) begin
            if (t_state[T1_IDX]) begin
                cw[CW_EP] = 1'b1;
                cw[CW_LM] = 1'b1;
            end
            if (t_state[T2_IDX]) begin
                cw[CW_CP] = 1'b1;
            end
            if (t_state[T3_IDX]) begin
                cw[CW_CE] = 1'b1;
                cw[CW_LI] = 1'b1;
            end
            if (t_state[T4_IDX]) begin
                if (is_mem) begin
                    cw[CW_EI] = 1'b1;
                    cw[CW_LM] = 1'b1;
                end
                if (is_out) begin
                    cw[CW_EA] = 1'b1;
                    cw[CW_LO] = 1'b1;
                end
            end
            if (t_state[T5_IDX]) begin
                if (is_lda) begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LA] = 1'b1;
                end
                if (is_add || is_sub) begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LB] = 1'b1;
                end
            end
            if (t_state[T6_IDX]) begin
                if (is_add || is_sub) begin
                    cw[CW_EU] = 1'b1;
                    cw[CW_LA] = 1'b1;
                end
                if (is_sub) begin
                    cw[CW_SU] = 1'b1;
                end
            end
        end
    end

    assign o_t   = t_state;
    assign o_cp  = cw[CW_CP];
    assign o_ep  = cw[CW_EP];
    assign o_lm  = cw[CW_LM];
    assign o_ce  = cw[CW_CE];
    assign o_li  = cw[CW_LI];
    assign o_ei  = cw[CW_EI];
    assign o_la  = cw[CW_LA];
    assign o_ea  = cw[CW_EA];
    assign o_su  = cw[CW_SU];
    assign o_eu  = cw[CW_EU];
    assign o_lb  = cw[CW_LB];
    assign o_lo  = cw[CW_LO];
    assign o_hlt = halt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// ---------------------------------------------------------------------------
// tb_controller_sequencer
// Self-checking bench for controller_sequencer. A behavioural model tracks the
// instruction step (0..5), the halt flag and the reset state, and derives the
// expected ring and strobes from the instruction micro-step table. Directed
// phases are followed by a randomized opcode stream with async clear pulses.
// ---------------------------------------------------------------------------
module tb_controller_sequencer;

    import sap1_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  opcode = 4'h0;
    logic [5:0]  t;
    logic        cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_step = 0;
    bit m_halt = 1'b0;

    controller_sequencer #(
        .OPCODE_WIDTH (4),
        .RING_LEN     (6)
    ) dut (
        .i_clk    (clk),
        .i_clr    (clr),
        .i_opcode (opcode),
        .o_t      (t),
        .o_cp     (cp),
        .o_ep     (ep),
        .o_lm     (lm),
        .o_ce     (ce),
        .o_li     (li),
        .o_ei     (ei),
        .o_la     (la),
        .o_ea     (ea),
        .o_su     (su),
        .o_eu     (eu),
        .o_lb     (lb),
        .o_lo     (lo),
        .o_hlt    (hlt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CW_WIDTH-1:0] dut_cw();
        logic [CW_WIDTH-1:0] v;
        v = '0;
        v[CW_CP] = cp; v[CW_EP] = ep; v[CW_LM] = lm; v[CW_CE] = ce;
        v[CW_LI] = li; v[CW_EI] = ei; v[CW_LA] = la; v[CW_EA] = ea;
        v[CW_SU] = su; v[CW_EU] = eu; v[CW_LB] = lb; v[CW_LO] = lo;
        return v;
    endfunction

    // Micro-step table: which strobes an instruction asserts at a given step.
    function automatic logic [CW_WIDTH-1:0] exp_cw(input int step, input logic [3:0] op);
        logic [CW_WIDTH-1:0] v;
        v = '0;
        case (step)
            0: begin v[CW_EP] = 1'b1; v[CW_LM] = 1'b1; end
            1: v[CW_CP] = 1'b1;
            2: begin v[CW_CE] = 1'b1; v[CW_LI] = 1'b1; end
            3: begin
                if (op == 4'h0 || op == 4'h1 || op == 4'h2) begin
                    v[CW_EI] = 1'b1; v[CW_LM] = 1'b1;
                end else if (op == 4'hE) begin
                    v[CW_EA] = 1'b1; v[CW_LO] = 1'b1;
                end
            end
            4: begin
                if (op == 4'h0) begin
                    v[CW_CE] = 1'b1; v[CW_LA] = 1'b1;
                end else if (op == 4'h1 || op == 4'h2) begin
                    v[CW_CE] = 1'b1; v[CW_LB] = 1'b1;
                end
            end
            5: begin
                if (op == 4'h1 || op == 4'h2) begin
                    v[CW_EU] = 1'b1; v[CW_LA] = 1'b1;
                end
                if (op == 4'h2) v[CW_SU] = 1'b1;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    // Index of the final step of an instruction.
    function automatic int last_step(input logic [3:0] op);
`ifdef SHORT_CYCLE_EN
        if (op == 4'hE) return 3;
        if (op == 4'h0 || op == 4'h1 || op == 4'h2 || op == 4'hF) return 5;
        return 2;
`else
        return 5 + 0 * int'(op);
`endif
    endfunction

    function automatic int exp_period(input logic [3:0] op);
        return last_step(op) + 1;
    endfunction

    // Model advance on each rising edge.
    always @(posedge clk) begin
        if (clr) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (m_halt) begin
            m_step = m_step;
        end else if (m_step == 3 && opcode == 4'hF) begin
            m_halt = 1'b1;
        end else if (m_step == last_step(opcode)) begin
            m_step = 0;
        end else begin
            m_step = m_step + 1;
        end
    end

    task automatic check_outputs(input string tag);
        logic [5:0]          e_t;
        logic [CW_WIDTH-1:0] e_cw;
        logic                e_h;
        e_t  = clr ? 6'b000001 : (6'b000001 << m_step);
        e_cw = (clr || m_halt) ? '0 : exp_cw(m_step, opcode);
        e_h  = clr ? 1'b0 : m_halt;
        check_val({tag, "_t"},   32'(t),        32'(e_t));
        check_val({tag, "_cw"},  32'(dut_cw()), 32'(e_cw));
        check_val({tag, "_hlt"}, 32'(hlt),      32'(e_h));
    endtask

    task automatic tick(input logic [3:0] op, input string tag);
        @(negedge clk);
        opcode = op;
        #1;
        check_outputs(tag);
    endtask

    // Called a little after a negedge: clear asynchronously mid-cycle, check
    // before the next posedge, hold across that edge, release at the negedge.
    task automatic clr_pulse(input string tag);
        #2;
        clr = 1'b1;
        m_step = 0;
        m_halt = 1'b0;
        #1;
        check_outputs(tag);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_outputs({tag, "_rel"});
    endtask

    task automatic measure_period(input logic [3:0] op, input string tag);
        int n;
        clr_pulse({tag, "_align"});
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick(op, tag);
            n++;
            if (t == 6'b000001) break;
        end
        check_val({tag, "_period"}, 32'(n), 32'(exp_period(op)));
        $display("txn %s: op=%h period=%0d", tag, op, n);
    endtask

    initial begin
        int drv;
        // Reset state
        clr = 1'b1;
        opcode = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs("reset");
        check_val("reset_t_const", 32'(t), 32'h01);
        $display("txn reset: t=%h hlt=%0d", t, hlt);

        // LDA: T1..T6 and wrap
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_outputs("lda");
        for (int i = 0; i < 6; i++) tick(4'h0, "lda");
        check_val("lda_wrap_t", 32'(t), 32'h01);
        $display("txn lda: one instruction, wrapped to t=%h", t);

        // SUB then ADD, checking the T6 subtract strobe explicitly
        for (int i = 0; i < 6; i++) begin
            tick(4'h2, "sub");
            if (m_step == 5) check_val("sub_t6_su", 32'(su), 32'h1);
        end
        for (int i = 0; i < 6; i++) begin
            tick(4'h1, "add");
            if (m_step == 5) check_val("add_t6_su", 32'(su), 32'h0);
        end
        $display("txn sub/add: done");

        // HLT: freeze at T4 for well over 20 cycles, opcode ignored while halted
        for (int i = 0; i < 25; i++) tick(4'hF, "hlt");
        check_val("hlt_frozen_t", 32'(t), 32'h08);
        for (int i = 0; i < 5; i++) tick(4'($urandom_range(0, 15)), "hlt_ign");
        clr_pulse("hlt_clr");
        $display("txn hlt: frozen then cleared, t=%h hlt=%0d", t, hlt);

        // Async clear in the middle of T5
        for (int i = 0; i < 8; i++) begin
            if (m_step == 4) break;
            tick(4'h0, "to_t5");
        end
        check_val("reached_t5", 32'(t), 32'h10);
        clr_pulse("mid_t5_clr");
        check_val("mid_t5_rel_ep", 32'(ep), 32'h1);
        $display("txn async clear mid-T5: t=%h", t);

        // Instruction periods for OUT and an undefined opcode
        measure_period(4'hE, "out");
        measure_period(4'h5, "nop");

        // Random opcode stream with invariant checks
        for (int c = 0; c < 10000; c++) begin
            logic [3:0] op;
            int         ndrv;
            op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            tick(op, "rnd");
            ndrv = int'(ep) + int'(ce) + int'(ei) + int'(ea) + int'(eu);
            check_val("rnd_onehot", 32'($countones(t)), 32'h1);
            check_val("rnd_one_driver", 32'(ndrv <= 1), 32'h1);
            if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
                clr_pulse("rnd_clr");
            end
        end
        drv = n_checks;
        $display("txn random: checks so far=%0d", drv);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
